// File: rtl/sha256_job_scheduler.sv
// sha256_job_scheduler: queues hash jobs and dispatches them one at a time to a
// single SHA-256 core over its start/done handshake, with a per-job watchdog.
module sha256_job_scheduler #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [15:0]      job_msg_addr,
  input  logic [15:0]      job_out_addr,
  input  logic [TAG_W-1:0] job_tag,
  output logic             core_start,
  output logic [15:0]      core_message_addr,
  output logic [15:0]      core_output_addr,
  input  logic             core_done,
  output logic             cmp_valid,
  output logic [TAG_W-1:0] cmp_tag,
  output logic             cmp_timeout,
  output logic             busy,
  output logic [15:0]      jobs_done
);

  localparam int            AW         = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT   = (AW+1)'(DEPTH);
  localparam logic [15:0]   WDOG_LIMIT = 16'(TIMEOUT);

  typedef struct packed {
    logic [15:0]      msg_addr;
    logic [15:0]      out_addr;
    logic [TAG_W-1:0] tag;
  } job_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_ACK,
    S_RUN,
    S_COMPLETE,
    S_DRAIN
  } state_t;

  job_t             fifo_mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  job_t             head;

  state_t           state;
  state_t           state_d;
  logic [15:0]      wdog;
  logic [15:0]      wdog_d;
  logic             timeout_q;
  logic             timeout_d;
  logic [TAG_W-1:0] hold_tag;

  // Ready depends only on the registered occupancy, never on core_done.
  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign job_ready  = ~fifo_full;
  assign push       = job_valid & ~fifo_full;
  assign head       = fifo_mem[rd_ptr];
  assign busy       = (state != S_IDLE) | ~fifo_empty;

  // Job storage: written on accept, read at the head pointer.
  // NOTE: the storage array has no reset; count guards every read, and leaving it
  // unreset lets it map onto plain RAM/flops without a reset tree.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{job_msg_addr, job_out_addr, job_tag};
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Next-state, pop and watchdog logic for the dispatch FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d   = state;
    wdog_d    = wdog;
    timeout_d = timeout_q;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        wdog_d    = '0;
        timeout_d = 1'b0;
        // An X on core_done makes this condition false, so the FSM waits.
        if (!fifo_empty && (core_done == 1'b1)) begin
          pop     = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        wdog_d  = wdog + 16'd1;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (wdog == WDOG_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = S_COMPLETE;
        end else if (core_done == 1'b0) begin
          wdog_d  = '0;
          state_d = S_RUN;
        end else begin
          wdog_d = wdog + 16'd1;
        end
      end
      S_RUN: begin
        if (core_done == 1'b1) begin
          state_d = S_COMPLETE;
        end else if (wdog == WDOG_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = S_COMPLETE;
        end else begin
          wdog_d = wdog + 16'd1;
        end
      end
      S_COMPLETE: begin
        state_d = timeout_q ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (core_done == 1'b1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, watchdog and timeout flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      wdog      <= '0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      state     <= state_d;
      wdog      <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  // Registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_start        <= 1'b0;
      core_message_addr <= '0;
      core_output_addr  <= '0;
      hold_tag          <= '0;
      cmp_valid         <= 1'b0;
      cmp_tag           <= '0;
      cmp_timeout       <= 1'b0;
      jobs_done         <= '0;
    end else begin
      core_start  <= (state_d == S_LAUNCH);
      cmp_valid   <= (state_d == S_COMPLETE);
      cmp_tag     <= (state_d == S_COMPLETE) ? hold_tag : '0;
      cmp_timeout <= (state_d == S_COMPLETE) & timeout_d;
      // Addresses only change on a pop, which requires the core to be idle.
      if (pop) begin
        core_message_addr <= head.msg_addr;
        core_output_addr  <= head.out_addr;
        hold_tag          <= head.tag;
      end
      if ((state_d == S_COMPLETE) && (jobs_done != 16'hFFFF)) begin
        jobs_done <= jobs_done + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sha256_job_scheduler.sv
// Directed testbench for sha256_job_scheduler with a simple start/done core model.
module tb_sha256_job_scheduler;

  logic        clk;
  logic        reset_n;
  logic        job_valid;
  logic        job_ready;
  logic [15:0] job_msg_addr;
  logic [15:0] job_out_addr;
  logic [3:0]  job_tag;
  logic        core_start;
  logic [15:0] core_message_addr;
  logic [15:0] core_output_addr;
  logic        core_done;
  logic        cmp_valid;
  logic [3:0]  cmp_tag;
  logic        cmp_timeout;
  logic        busy;
  logic [15:0] jobs_done;

  int n_checks = 0;
  int n_pass   = 0;

  // Core model controls.
  logic model_done   = 1'b1;
  logic core_hold    = 1'b0;
  logic core_x       = 1'b0;
  logic core_stuck   = 1'b0;
  logic core_release = 1'b0;
  int   core_cycles  = 20;

  // Monitor state.
  int          cyc = 0;
  int          start_cnt = 0;
  int          cmp_cnt = 0;
  int          last_start_cyc = 0;
  int          cmp_cyc = 0;
  int          viol_start = 0;
  int          viol_addr = 0;
  int          viol_pulse = 0;
  logic        prev_ok = 1'b0;
  logic        prev_done = 1'b1;
  logic        prev_cmp = 1'b0;
  logic [15:0] prev_msg = '0;
  logic [15:0] prev_out = '0;

  assign core_done = core_x ? 1'bx : (model_done & ~core_hold);

  sha256_job_scheduler #(.DEPTH(4), .TAG_W(4), .TIMEOUT(256)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .job_valid         (job_valid),
    .job_ready         (job_ready),
    .job_msg_addr      (job_msg_addr),
    .job_out_addr      (job_out_addr),
    .job_tag           (job_tag),
    .core_start        (core_start),
    .core_message_addr (core_message_addr),
    .core_output_addr  (core_output_addr),
    .core_done         (core_done),
    .cmp_valid         (cmp_valid),
    .cmp_tag           (cmp_tag),
    .cmp_timeout       (cmp_timeout),
    .busy              (busy),
    .jobs_done         (jobs_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: takes start at the edge after it is seen high, drops done,
  // runs core_cycles cycles (or until released when stuck), raises done.
  always begin
    @(negedge clk);
    if (core_start === 1'b1) begin
      @(posedge clk);
      #1 model_done = 1'b0;
      if (core_stuck) wait (core_release == 1'b1);
      else repeat (core_cycles - 1) @(posedge clk);
      @(posedge clk);
      #1 model_done = 1'b1;
    end
  end

  // Protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (reset_n) begin
      if (core_start === 1'b1) begin
        start_cnt      <= start_cnt + 1;
        last_start_cyc <= cyc;
        if (core_done !== 1'b1) viol_start <= viol_start + 1;
      end
      if (cmp_valid === 1'b1) begin
        cmp_cnt <= cmp_cnt + 1;
        cmp_cyc <= cyc;
        if (prev_cmp) viol_pulse <= viol_pulse + 1;
      end
      if (prev_ok && (prev_done === 1'b0) && (core_done === 1'b0) &&
          ((prev_msg !== core_message_addr) || (prev_out !== core_output_addr)))
        viol_addr <= viol_addr + 1;
    end
    prev_ok   <= reset_n;
    prev_done <= core_done;
    prev_cmp  <= (cmp_valid === 1'b1);
    prev_msg  <= core_message_addr;
    prev_out  <= core_output_addr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Step to just after the next falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] m, input logic [15:0] o, input logic [3:0] t);
    logic r;
    int   n;
    n = 0;
    job_valid    = 1'b1;
    job_msg_addr = m;
    job_out_addr = o;
    job_tag      = t;
    do begin
      r = job_ready;
      @(posedge clk);
      tick();
      n++;
    end while (!r && n < 50);
    job_valid = 1'b0;
    check("push_accept", 32'(r), 32'd1);
  endtask

  task automatic wait_cmp(input string tag, input int budget);
    int n;
    n = 0;
    tick();
    while (cmp_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(cmp_valid), 32'd1);
  endtask

  int s0;
  int c0;

  initial begin
    reset_n = 1'b1;
    job_valid = 1'b0;
    job_msg_addr = '0;
    job_out_addr = '0;
    job_tag = '0;
    #1 reset_n = 1'b0;
    #2;
    check("rst_ready", 32'(job_ready), 32'd1);
    check("rst_start", 32'(core_start), 32'd0);
    check("rst_msg", 32'(core_message_addr), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmp", 32'(cmp_valid), 32'd0);
    check("rst_jobs", 32'(jobs_done), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // 1: single job, 130-cycle core; start high exactly one cycle after E1.
    core_cycles = 130;
    push(16'h0000, 16'h0010, 4'd3);
    check("t1_start_e0", 32'(core_start), 32'd0);
    tick();
    check("t1_start_e1", 32'(core_start), 32'd1);
    tick();
    check("t1_start_e2", 32'(core_start), 32'd0);
    check("t1_msg", 32'(core_message_addr), 32'h0000);
    check("t1_out", 32'(core_output_addr), 32'h0010);
    check("t1_busy", 32'(busy), 32'd1);
    wait_cmp("t1_cmp_seen", 300);
    check("t1_tag", 32'(cmp_tag), 32'd3);
    check("t1_timeout", 32'(cmp_timeout), 32'd0);
    check("t1_jobs", 32'(jobs_done), 32'd1);
    tick();
    check("t1_cmp_pulse", 32'(cmp_valid), 32'd0);
    check("t1_starts", 32'(start_cnt), 32'd1);

    // 2: three back-to-back jobs, completions in order with matching addresses.
    core_cycles = 20;
    s0 = start_cnt;
    push(16'h1000, 16'h2000, 4'd1);
    push(16'h1100, 16'h2100, 4'd2);
    push(16'h1200, 16'h2200, 4'd3);
    for (int i = 0; i < 3; i++) begin
      wait_cmp("t2_cmp_seen", 100);
      check("t2_tag", 32'(cmp_tag), 32'(i + 1));
      check("t2_msg", 32'(core_message_addr), 32'(16'h1000 + 16'(i * 16'h100)));
    end
    check("t2_jobs", 32'(jobs_done), 32'd4);
    #1;
    check("t2_starts", 32'(start_cnt - s0), 32'd3);

    // 3: fill the FIFO with the core stalled; 5th accepted the cycle after the first pop.
    core_hold = 1'b1;
    core_cycles = 8;
    s0 = start_cnt;
    for (int i = 1; i <= 4; i++) push(16'h0100 + 16'(i), 16'h0200 + 16'(i), 4'(i));
    check("t3_full_ready", 32'(job_ready), 32'd0);
    job_valid = 1'b1;
    job_msg_addr = 16'h0105;
    job_out_addr = 16'h0205;
    job_tag = 4'd5;
    repeat (3) tick();
    check("t3_held_ready", 32'(job_ready), 32'd0);
    check("t3_no_launch", 32'(start_cnt - s0), 32'd0);
    core_hold = 1'b0;
    tick();
    check("t3_ready_after_pop", 32'(job_ready), 32'd1);
    tick();
    job_valid = 1'b0;
    check("t3_refull", 32'(job_ready), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      wait_cmp("t3_cmp_seen", 100);
      check("t3_tag", 32'(cmp_tag), 32'(i));
    end
    check("t3_jobs", 32'(jobs_done), 32'd9);

    // 4: stuck core times out; the next job waits until done returns.
    tick();
    core_stuck = 1'b1;
    push(16'h0A00, 16'h0B00, 4'd5);
    push(16'h0A10, 16'h0B10, 4'd6);
    wait_cmp("t4_cmp_seen", 400);
    check("t4_tag", 32'(cmp_tag), 32'd5);
    check("t4_timeout", 32'(cmp_timeout), 32'd1);
    #1;
    // start seen at negedge after E1; RUN entered at E3 with watchdog 0; the edge
    // that sees watchdog==256 is E260, so cmp_valid is seen 259 negedges later.
    check("t4_latency", 32'(cmp_cyc - last_start_cyc), 32'd259);
    s0 = start_cnt;
    repeat (20) tick();
    check("t4_drain_hold", 32'(start_cnt - s0), 32'd0);
    check("t4_busy", 32'(busy), 32'd1);
    core_stuck = 1'b0;
    core_release = 1'b1;
    for (int n = 0; n < 10 && model_done !== 1'b1; n++) tick();
    core_release = 1'b0;
    wait_cmp("t4_resume_seen", 100);
    check("t4_resume_tag", 32'(cmp_tag), 32'd6);
    check("t4_resume_to", 32'(cmp_timeout), 32'd0);
    check("t4_jobs", 32'(jobs_done), 32'd11);

    // 5: reset mid-RUN with two jobs queued, then a fresh job with done=X while idle.
    tick();
    core_cycles = 60;
    s0 = start_cnt;
    push(16'h0C00, 16'h0D00, 4'd8);
    push(16'h0C10, 16'h0D10, 4'd9);
    push(16'h0C20, 16'h0D20, 4'd10);
    for (int n = 0; n < 20 && start_cnt == s0; n++) tick();
    repeat (10) tick();
    check("t5_busy_pre", 32'(busy), 32'd1);
    c0 = cmp_cnt;
    reset_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_jobs", 32'(jobs_done), 32'd0);
    check("t5_rst_out", 32'(core_output_addr), 32'h0);
    check("t5_rst_ready", 32'(job_ready), 32'd1);
    for (int n = 0; n < 100 && model_done !== 1'b1; n++) tick();
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("t5_no_cmp", 32'(cmp_cnt - c0), 32'd0);
    check("t5_idle", 32'(busy), 32'd0);
    core_cycles = 12;
    core_x = 1'b1;
    s0 = start_cnt;
    push(16'h0E00, 16'h0F00, 4'd7);
    repeat (4) tick();
    check("t5_x_wait", 32'(start_cnt - s0), 32'd0);
    core_x = 1'b0;
    wait_cmp("t5_cmp_seen", 100);
    check("t5_tag", 32'(cmp_tag), 32'd7);
    check("t5_jobs", 32'(jobs_done), 32'd1);

    // 6: push a job in the very cycle the previous one completes.
    tick();
    core_cycles = 15;
    push(16'h3000, 16'h3100, 4'd4);
    wait_cmp("t6_cmp_a_seen", 100);
    check("t6_tag_a", 32'(cmp_tag), 32'd4);
    check("t6_jobs_a", 32'(jobs_done), 32'd2);
    s0 = start_cnt;
    job_valid = 1'b1;
    job_msg_addr = 16'h3200;
    job_out_addr = 16'h3300;
    job_tag = 4'd5;
    check("t6_ready", 32'(job_ready), 32'd1);
    tick();
    job_valid = 1'b0;
    check("t6_jobs_once", 32'(jobs_done), 32'd2);
    wait_cmp("t6_cmp_b_seen", 100);
    check("t6_tag_b", 32'(cmp_tag), 32'd5);
    check("t6_msg_b", 32'(core_message_addr), 32'h3200);
    check("t6_jobs_b", 32'(jobs_done), 32'd3);
    #1;
    check("t6_launch", 32'(start_cnt - s0), 32'd1);

    // Protocol invariants across the whole run.
    check("start_while_busy", 32'(viol_start), 32'd0);
    check("addr_change_busy", 32'(viol_addr), 32'd0);
    check("cmp_pulse_width", 32'(viol_pulse), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
